cpu_mem_responder: RTL and testbench
====================================

Name: cpu_mem_responder

Overview:
- Memory-side responder for the 8-bit CPU bus. It answers the CPU's addr_bus / mem_read / mem_write requests with ROM and RAM storage.
- Address decode: ROM at addresses below ROM_SIZE, RAM from ROM_SIZE upward.
- Adds programmable wait states and a one-cycle mem_ready completion pulse.
- Drives the shared tri-state data_bus on reads and captures the CPU's accumulator output on writes.
- Sits between cpu_top and system storage, and replaces the behavioural memory model.

Parameters:
- ROM_SIZE, 256, number of ROM bytes; ROM occupies 0x0000..ROM_SIZE-1.
- RAM_AW, 12, RAM index width; RAM depth is 2^RAM_AW bytes.
- WAIT_STATES, 1, extra cycles inserted before completion (0..15).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- addr_bus  input  16  CPU address.
- mem_read  input  1  CPU read request.
- mem_write  input  1  CPU write request.
- wdata  input  8  write data, connected to cpu acc_out.
- data_bus  inout  8  shared data bus; driven only in read RESP, else high-Z.
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  high in WAIT and RESP.
- rom_wr_err  output  1  sticky flag: a write was attempted to the ROM region.
- bus_err  output  1  sticky flag: mem_read and mem_write were both high at acceptance.
- rom_we  input  1  ROM load strobe (boot loader).
- rom_waddr  input  16  ROM load address.
- rom_wdata  input  8  ROM load data.
- txn_count  output  16  completed transactions; wraps at 0xFFFF->0x0000.

Behaviour:
- Reset (async, any state):
  - state=IDLE; mem_ready=0, busy=0, rom_wr_err=0, bus_err=0, txn_count=0.
  - data_bus=Z; wait counter=0.
  - ROM/RAM contents are not cleared.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - At the edge where mem_read or mem_write is high, latch addr, type and wdata. Call this edge k.
  - If WAIT_STATES=0, go to RESP. Otherwise go to WAIT with cnt=WAIT_STATES.
- WAIT:
  - cnt decrements each edge. When cnt==1, go to RESP on the next edge.
  - The request is latched, so deasserting mem_read/mem_write during WAIT does not abort it.
- Transition into RESP, which occurs at edge k+WAIT_STATES:
  - Read: rdata is registered from ROM (addr<ROM_SIZE) or RAM (index=(addr-ROM_SIZE) mod 2^RAM_AW, wraps).
  - Write, RAM region: the RAM byte is written with the latched wdata.
  - Write, ROM region: no store; rom_wr_err is set.
  - Both request lines high at acceptance: no access; bus_err is set; rdata=0xFF.
- RESP (exactly one cycle):
  - mem_ready=1 and txn_count increments.
  - data_bus=rdata if the transaction is a read; otherwise Z.
  - Next state is always IDLE, so back-to-back requests have at least one IDLE cycle between them.
- Latency: mem_ready is high during the cycle after edge k+WAIT_STATES, i.e. WAIT_STATES+1 cycles after acceptance.
- ROM load:
  - Honoured only when state==IDLE: rom[rom_waddr] is written, for rom_waddr<ROM_SIZE only.
  - Ignored when busy or when out of range.
  - A load and a read of the same address on the same edge (WAIT_STATES=0): the read returns the old byte.
- data_bus is never driven outside read RESP, which prevents contention with CPU drive.
- Sticky error flags clear only on reset.

Test Plan:
- WAIT_STATES=1; ROM load 0x0000=0xA9, 0x0001=0x55; read 0x0001 -> mem_ready high 2 cycles after acceptance, data_bus=0x55 that cycle only, Z otherwise; txn_count=1.
- Write 0x3C to 0x0200, then read 0x0200 -> read returns 0x3C; write completes with mem_ready, data_bus stays Z throughout.
- Write 0x77 to 0x0010 (ROM) -> rom_wr_err=1, mem_ready pulses, subsequent read of 0x0010 returns the original byte.
- mem_read and mem_write both high at 0x0300 -> bus_err=1, data_bus=0xFF in RESP, RAM[0x0300] unchanged.
- WAIT_STATES=3; assert reset during WAIT -> busy=0, mem_ready=0, data_bus=Z immediately; a RAM byte written earlier is still readable afterward.
- RAM wrap, RAM_AW=12: write 0x11 to 0x0100, read 0x1100 -> returns 0x11.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 8-bit CPU bus: ROM below ROM_SIZE, RAM above,
// with programmable wait states, a one-cycle mem_ready pulse and sticky error flags.
module cpu_mem_responder #(
  parameter int ROM_SIZE    = 256,
  parameter int RAM_AW      = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_bus,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [7:0]  wdata,
  inout  wire  [7:0]  data_bus,
  output logic        mem_ready,
  output logic        busy,
  output logic        rom_wr_err,
  output logic        bus_err,
  input  logic        rom_we,
  input  logic [15:0] rom_waddr,
  input  logic [7:0]  rom_wdata,
  output logic [15:0] txn_count
);

  localparam int          ROM_AW    = $clog2(ROM_SIZE);
  localparam logic [15:0] ROM_LIMIT = 16'(ROM_SIZE);
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [15:0] addr_q;
  logic        rd_q, wr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;

  logic [7:0]  rom [ROM_SIZE];
  logic [7:0]  ram [2**RAM_AW];

  // With zero wait states the access happens on the accepting edge itself,
  // so the live request is used in IDLE and the latched copy afterwards.
  logic              req;
  logic [15:0]       acc_addr;
  logic              acc_rd, acc_wr;
  logic [7:0]        acc_wdata;
  logic              acc_in_rom;
  logic [ROM_AW-1:0] rom_idx;
  logic [RAM_AW-1:0] ram_idx;
  logic              enter_resp;
  logic              rom_load;

  assign req        = mem_read | mem_write;
  assign acc_addr   = (state == IDLE) ? addr_bus  : addr_q;
  assign acc_rd     = (state == IDLE) ? mem_read  : rd_q;
  assign acc_wr     = (state == IDLE) ? mem_write : wr_q;
  assign acc_wdata  = (state == IDLE) ? wdata     : wdata_q;
  assign acc_in_rom = acc_addr < ROM_LIMIT;
  assign rom_idx    = ROM_AW'(acc_addr);
  assign ram_idx    = RAM_AW'(acc_addr) - RAM_AW'(ROM_SIZE);
  assign enter_resp = (state_nxt == RESP);
  assign rom_load   = (state == IDLE) && rom_we && (rom_waddr < ROM_LIMIT);

  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE: if (req) state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= 16'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= 8'd0;
      rdata_q    <= 8'd0;
      rom_wr_err <= 1'b0;
      bus_err    <= 1'b0;
      txn_count  <= 16'd0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && req) begin
        addr_q  <= addr_bus;
        rd_q    <= mem_read;
        wr_q    <= mem_write;
        wdata_q <= wdata;
        cnt     <= WS;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end

      if (enter_resp) begin
        if (acc_rd && acc_wr) begin
          bus_err <= 1'b1;
          rdata_q <= 8'hFF;
        end else if (acc_rd) begin
          rdata_q <= acc_in_rom ? rom[rom_idx] : ram[ram_idx];
        end else if (acc_in_rom) begin
          rom_wr_err <= 1'b1;
        end
      end

      if (state == RESP) txn_count <= txn_count + 16'd1;
    end
  end

  // NOTE: storage arrays are deliberately not reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_wr && !acc_rd && !acc_in_rom) ram[ram_idx] <= acc_wdata;
    if (rom_load) rom[ROM_AW'(rom_waddr)] <= rom_wdata;
  end

  assign busy      = (state != IDLE);
  assign mem_ready = (state == RESP);
  // A conflicting request latched rd_q too, so its 0xFF response is driven.
  assign data_bus  = (state == RESP && rd_q) ? rdata_q : 8'hzz;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: table of transactions on a 1-wait-state
// instance plus hand sequences for busy-time ROM loads and reset during WAIT.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  int          n_checks = 0;
  int          n_err    = 0;

  // Instance A: WAIT_STATES = 1
  logic        reset;
  logic [15:0] addr_bus;
  logic        mem_read, mem_write;
  logic [7:0]  wdata;
  tri0  [7:0]  data_bus;
  logic        mem_ready, busy, rom_wr_err, bus_err;
  logic        rom_we;
  logic [15:0] rom_waddr;
  logic [7:0]  rom_wdata;
  logic [15:0] txn_count;

  // Instance B: WAIT_STATES = 3
  logic        s3_reset;
  logic [15:0] s3_addr_bus;
  logic        s3_mem_read, s3_mem_write;
  logic [7:0]  s3_wdata;
  tri0  [7:0]  s3_data_bus;
  logic        s3_mem_ready, s3_busy, s3_rom_wr_err, s3_bus_err;
  logic [15:0] s3_txn_count;

  always #5 clk = ~clk;

  cpu_mem_responder #(.ROM_SIZE(256), .RAM_AW(12), .WAIT_STATES(1)) u_dut (
    .clk(clk), .reset(reset), .addr_bus(addr_bus), .mem_read(mem_read),
    .mem_write(mem_write), .wdata(wdata), .data_bus(data_bus),
    .mem_ready(mem_ready), .busy(busy), .rom_wr_err(rom_wr_err), .bus_err(bus_err),
    .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata), .txn_count(txn_count)
  );

  cpu_mem_responder #(.ROM_SIZE(256), .RAM_AW(12), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset(s3_reset), .addr_bus(s3_addr_bus), .mem_read(s3_mem_read),
    .mem_write(s3_mem_write), .wdata(s3_wdata), .data_bus(s3_data_bus),
    .mem_ready(s3_mem_ready), .busy(s3_busy), .rom_wr_err(s3_rom_wr_err),
    .bus_err(s3_bus_err), .rom_we(1'b0), .rom_waddr(16'h0000), .rom_wdata(8'h00),
    .txn_count(s3_txn_count)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  exp_bus;      // bus value in the ready cycle (0 = undriven, tri0)
    logic        exp_rom_err;  // cumulative sticky value after the transaction
    logic        exp_bus_err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rom_load(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    rom_we = 1'b1; rom_waddr = a; rom_wdata = d;
    @(negedge clk);
    rom_we = 1'b0;
  endtask

  // One transaction on instance A; returns the bus value in the ready cycle
  // and the latency in cycles counting the accepting cycle as 1.
  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [7:0] wd, output logic [7:0] bus_val, output int lat);
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr_bus = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; addr_bus = 16'hDEAD; wdata = 8'hC3;
    lat = 1;
    while (!mem_ready && lat < 20) begin
      check("wait_bus_z", 16'(data_bus), 16'h0000);
      check("wait_busy", 16'(busy), 16'h0001);
      @(negedge clk);
      lat++;
    end
    if (!mem_ready) check("ready_timeout", 16'(mem_ready), 16'h0001);
    bus_val = data_bus;
    @(negedge clk);
    check("ready_pulse_width", 16'(mem_ready), 16'h0000);
    check("idle_after_resp", 16'(busy), 16'h0000);
    check("idle_bus_z", 16'(data_bus), 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bv;
    int         lat;

    vecs[0]  = '{1'b1, 1'b0, 16'h0001, 8'h00, 8'h55, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'h0200, 8'h3C, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h0200, 8'h00, 8'h3C, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'h0010, 8'h77, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'h0010, 8'h00, 8'h5A, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'h0100, 8'h11, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 16'h1100, 8'h00, 8'h11, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'h0300, 8'h22, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 16'h0300, 8'h99, 8'hFF, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 16'h0300, 8'h00, 8'h22, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'hA9, 1'b1, 1'b1};

    reset = 1'b1; addr_bus = 16'h0; mem_read = 1'b0; mem_write = 1'b0; wdata = 8'h0;
    rom_we = 1'b0; rom_waddr = 16'h0; rom_wdata = 8'h0;
    s3_reset = 1'b1; s3_addr_bus = 16'h0; s3_mem_read = 1'b0; s3_mem_write = 1'b0;
    s3_wdata = 8'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0; s3_reset = 1'b0;

    check("rst_ready", 16'(mem_ready), 16'h0000);
    check("rst_busy", 16'(busy), 16'h0000);
    check("rst_rom_err", 16'(rom_wr_err), 16'h0000);
    check("rst_bus_err", 16'(bus_err), 16'h0000);
    check("rst_txn", txn_count, 16'h0000);
    check("rst_bus_z", 16'(data_bus), 16'h0000);

    rom_load(16'h0000, 8'hA9);
    rom_load(16'h0001, 8'h55);
    rom_load(16'h0010, 8'h5A);
    rom_load(16'h0002, 8'h33);
    rom_load(16'h0100, 8'h99);  // out of range: must not alias onto 0x0000

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, bv, lat);
      check($sformatf("v%0d_latency", i), 16'(lat), 16'd2);
      check($sformatf("v%0d_bus", i), 16'(bv), 16'(vecs[i].exp_bus));
      check($sformatf("v%0d_rom_err", i), 16'(rom_wr_err), 16'(vecs[i].exp_rom_err));
      check($sformatf("v%0d_bus_err", i), 16'(bus_err), 16'(vecs[i].exp_bus_err));
      check($sformatf("v%0d_txn", i), txn_count, 16'(i + 1));
    end

    // ROM load attempted while busy must be ignored.
    @(negedge clk);
    mem_read = 1'b1; addr_bus = 16'h0002;
    @(negedge clk);
    mem_read = 1'b0;
    rom_we = 1'b1; rom_waddr = 16'h0002; rom_wdata = 8'hEE;
    check("busyload_busy", 16'(busy), 16'h0001);
    @(negedge clk);
    rom_we = 1'b0;
    check("busyload_ready", 16'(mem_ready), 16'h0001);
    check("busyload_bus", 16'(data_bus), 16'h0033);
    run_txn(1'b1, 1'b0, 16'h0002, 8'h00, bv, lat);
    check("busyload_reread", 16'(bv), 16'h0033);
    check("busyload_txn", txn_count, 16'd13);

    // Instance B: write with 3 wait states.
    @(negedge clk);
    s3_mem_write = 1'b1; s3_addr_bus = 16'h0400; s3_wdata = 8'h44;
    @(negedge clk);
    s3_mem_write = 1'b0; s3_addr_bus = 16'h0000; s3_wdata = 8'h00;
    repeat (2) @(negedge clk);
    check("ws3_wr_not_ready", 16'(s3_mem_ready), 16'h0000);
    check("ws3_wr_busy", 16'(s3_busy), 16'h0001);
    @(negedge clk);
    check("ws3_wr_ready", 16'(s3_mem_ready), 16'h0001);
    check("ws3_wr_bus_z", 16'(s3_data_bus), 16'h0000);
    @(negedge clk);
    check("ws3_wr_txn", s3_txn_count, 16'd1);

    // Reset in the middle of WAIT.
    s3_mem_read = 1'b1; s3_addr_bus = 16'h0400;
    @(negedge clk);
    s3_mem_read = 1'b0;
    check("ws3_inwait_busy", 16'(s3_busy), 16'h0001);
    #2 s3_reset = 1'b1;
    #1;
    check("ws3_rst_busy", 16'(s3_busy), 16'h0000);
    check("ws3_rst_ready", 16'(s3_mem_ready), 16'h0000);
    check("ws3_rst_bus_z", 16'(s3_data_bus), 16'h0000);
    check("ws3_rst_txn", s3_txn_count, 16'h0000);
    @(negedge clk);
    s3_reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("ws3_post_rst_idle", 16'(s3_mem_ready), 16'h0000);
    end

    // RAM contents survive reset.
    s3_mem_read = 1'b1; s3_addr_bus = 16'h0400;
    @(negedge clk);
    s3_mem_read = 1'b0;
    repeat (2) @(negedge clk);
    check("ws3_rd_not_ready", 16'(s3_mem_ready), 16'h0000);
    @(negedge clk);
    check("ws3_rd_ready", 16'(s3_mem_ready), 16'h0001);
    check("ws3_rd_data", 16'(s3_data_bus), 16'h0044);
    @(negedge clk);
    check("ws3_rd_bus_z_after", 16'(s3_data_bus), 16'h0000);
    check("ws3_rd_txn", s3_txn_count, 16'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
